// File: rtl/fetch_decode_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue.
package fetch_decode_queue_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0,x0,0 -- shared with decode and flush logic.
  localparam logic [XLEN-1:0] NOP_INSTRUCTION = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ins;
  } queue_entry_t;

endpackage

// File: rtl/ins_queue_ram.sv
// DEPTH x {pc, ins} register array: synchronous write, asynchronous read.
module ins_queue_ram
  import fetch_decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  queue_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output queue_entry_t rdata
);

  queue_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction queue decoupling I-cache returns from decode stalls; flush empties it.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int unsigned     DEPTH = 4,
  parameter logic [XLEN-1:0] NOP   = NOP_INSTRUCTION,
  localparam int unsigned    AW    = $clog2(DEPTH),
  localparam int unsigned    CW    = AW + 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            INS_CACHE_READY,
  input  logic [XLEN-1:0] FETCH_PC,
  input  logic [XLEN-1:0] FETCH_INSTRUCTION,
  output logic            FETCH_READY,
  input  logic            FLUSH,
  input  logic            STALL_ENABLE,
  input  logic            DATA_CACHE_READY,
  output logic [XLEN-1:0] INSTRUCTION,
  output logic [XLEN-1:0] PC_ID,
  output logic            INS_VALID,
  output logic [CW-1:0]   OCCUPANCY
);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  queue_entry_t  wdata;
  queue_entry_t  head;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Readiness depends only on registered count, never on this cycle's pop.
  assign push = INS_CACHE_READY & ~full & ~FLUSH;
  assign pop  = ~empty & STALL_ENABLE & DATA_CACHE_READY & ~FLUSH;

  assign wdata.pc  = FETCH_PC;
  assign wdata.ins = FETCH_INSTRUCTION;

  ins_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (CLK),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Stale storage is masked whenever the queue is empty.
  assign FETCH_READY = ~full;
  assign INS_VALID   = ~empty;
  assign INSTRUCTION = empty ? NOP : head.ins;
  assign PC_ID       = empty ? '0 : head.pc;
  assign OCCUPANCY   = count;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench: negedge monitor keeps a reference queue and checks every cycle.
module tb_fetch_decode_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOPV  = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST;
  logic        INS_CACHE_READY;
  logic [31:0] FETCH_PC;
  logic [31:0] FETCH_INSTRUCTION;
  logic        FETCH_READY;
  logic        FLUSH;
  logic        STALL_ENABLE;
  logic        DATA_CACHE_READY;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC_ID;
  logic        INS_VALID;
  logic [2:0]  OCCUPANCY;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];

  fetch_decode_queue #(.DEPTH(DEPTH)) dut (
    .CLK               (CLK),
    .RST               (RST),
    .INS_CACHE_READY   (INS_CACHE_READY),
    .FETCH_PC          (FETCH_PC),
    .FETCH_INSTRUCTION (FETCH_INSTRUCTION),
    .FETCH_READY       (FETCH_READY),
    .FLUSH             (FLUSH),
    .STALL_ENABLE      (STALL_ENABLE),
    .DATA_CACHE_READY  (DATA_CACHE_READY),
    .INSTRUCTION       (INSTRUCTION),
    .PC_ID             (PC_ID),
    .INS_VALID         (INS_VALID),
    .OCCUPANCY         (OCCUPANCY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(INS_VALID), 32'd0);
    check({tag, "_ins"},   INSTRUCTION, NOPV);
    check({tag, "_pc"},    PC_ID, 32'd0);
    check({tag, "_ready"}, 32'(FETCH_READY), 32'd1);
    check({tag, "_occ"},   32'(OCCUPANCY), 32'd0);
  endtask

  // Monitor: compare outputs against the reference queue, then apply this cycle's push/pop/flush.
  always @(negedge CLK) begin
    if (RST) begin
      exp_q.delete();
      check_reset_outputs("rst");
    end else begin
      int n;
      logic do_push, do_pop;
      n = exp_q.size();
      check("fetch_ready", 32'(FETCH_READY), 32'(n < DEPTH));
      check("ins_valid",   32'(INS_VALID),   32'(n != 0));
      check("occupancy",   32'(OCCUPANCY),   32'(n));
      if (n != 0) begin
        check("instruction", INSTRUCTION, exp_q[0].ins);
        check("pc_id",       PC_ID,       exp_q[0].pc);
      end else begin
        check("instruction_nop", INSTRUCTION, NOPV);
        check("pc_id_zero",      PC_ID,       32'd0);
      end
      do_push = INS_CACHE_READY && (n < DEPTH) && !FLUSH;
      do_pop  = (n != 0) && STALL_ENABLE && DATA_CACHE_READY && !FLUSH;
      if (FLUSH) exp_q.delete();
      else begin
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back('{pc: FETCH_PC, ins: FETCH_INSTRUCTION});
      end
    end
  end

  // Drive one cycle of inputs (called at posedge+1, returns at next posedge+1).
  task automatic cyc(input logic icr, input logic [31:0] pc, input logic [31:0] ins,
                     input logic fl, input logic st, input logic dc);
    INS_CACHE_READY   = icr;
    FETCH_PC          = pc;
    FETCH_INSTRUCTION = ins;
    FLUSH             = fl;
    STALL_ENABLE      = st;
    DATA_CACHE_READY  = dc;
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    RST = 1'b1;
    INS_CACHE_READY = 1'b0; FETCH_PC = '0; FETCH_INSTRUCTION = '0;
    FLUSH = 1'b0; STALL_ENABLE = 1'b0; DATA_CACHE_READY = 1'b1;
    #1;
    check_reset_outputs("por");
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;

    // Single push then pop.
    cyc(1'b1, 32'h100, 32'h0050_0093, 1'b0, 1'b1, 1'b1);
    drain(2);

    // Fill while decode stalls, fifth push refused, then drain in order.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'(i * 4), 32'hA000_0000 | 32'(i), 1'b0, 1'b0, 1'b1);
    drain(6);

    // Continuous push and pop across pointer wrap.
    for (int i = 0; i < 10; i++) cyc(1'b1, 32'(i * 4), 32'hB000_0000 | 32'(i), 1'b0, 1'b1, 1'b1);
    drain(2);

    // Flush with 3 queued and a simultaneous push.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h40 + 32'(i * 4), 32'hC000_0000 | 32'(i), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'h200, 32'hC000_0200, 1'b1, 1'b1, 1'b1);
    drain(2);

    // Data-cache freeze holds head while pushes continue.
    for (int i = 0; i < 2; i++) cyc(1'b1, 32'h80 + 32'(i * 4), 32'hD000_0000 | 32'(i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h88 + 32'(i * 4), 32'hD000_0010 | 32'(i), 1'b0, 1'b1, 1'b0);
    drain(6);

    // Asynchronous reset mid-stream with 3 entries.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h300 + 32'(i * 4), 32'hE000_0000 | 32'(i), 1'b0, 1'b0, 1'b1);
    INS_CACHE_READY = 1'b0;
    #1;
    RST = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge CLK);
    #1;
    RST = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) < 7),
          32'(i * 4) + 32'h1000,
          $urandom(),
          ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 9) < 8));
    end
    drain(6);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
